axi4_burst_fifo: RTL and testbench

Parametrised AXI4 slave that exposes a single FIFO through standard AXI4 bursts. Every write-burst beat is pushed, and every read-burst beat pops one entry. Addresses are not used. It replaces the fixed-width, single-depth FIFO front end. Depth, width and almost-full threshold are configurable, and per-burst response checking is included.

---
 rtl/axi4_fifo_pkg.sv | 32 +++
 rtl/axi4_fifo_core.sv | 65 ++++++
 rtl/axi4_burst_fifo.sv | 221 ++++++++++++++++++++++
 tb/tb_axi4_burst_fifo.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_fifo_pkg.sv
// ============================================================================
// Module   : axi4_fifo_pkg
// Brief    : Shared response encodings and FSM state types for axi4_burst_fifo.
// Revision : 1.0
// ============================================================================
`default_nettype none

package axi4_fifo_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    function automatic int ptr_wid(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_fifo_core.sv
// ============================================================================
// Module   : axi4_fifo_core
// Brief    : DEPTH x DATA_WID FIFO storage with wrap-bit pointers and status.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi4_fifo_core
    import axi4_fifo_pkg::*;
#(
    parameter int  DATA_WID  = 64,
    parameter int  DEPTH     = 16,
    parameter int  AFULL_THR = DEPTH - 2,
    localparam int PTR_WID   = ptr_wid(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [DATA_WID-1:0] wdata_i,
    input  logic                pop_i,
    output logic [DATA_WID-1:0] rdata_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                afull_o,
    output logic [PTR_WID-1:0]  level_o
);

    localparam int IDX_WID = PTR_WID - 1;

    logic [DATA_WID-1:0] mem_q [DEPTH];
    logic [PTR_WID-1:0]  wr_ptr_q;
    logic [PTR_WID-1:0]  rd_ptr_q;
    logic                do_push;
    logic                do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage is deliberately not reset; RDATA is undefined until written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[IDX_WID-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Modular difference: the wrap bit separates full (DEPTH) from empty (0).
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level_o == PTR_WID'(DEPTH));
    assign empty_o = (level_o == '0);
    assign afull_o = (level_o >= PTR_WID'(AFULL_THR));
    assign rdata_o = mem_q[rd_ptr_q[IDX_WID-1:0]];

endmodule

`default_nettype wire

// File: rtl/axi4_burst_fifo.sv
// ============================================================================
// Module   : axi4_burst_fifo
// Brief    : AXI4 slave exposing one FIFO; write beats push, read beats pop.
//            Optional AXI4_FIFO_UNDERFLOW_ERR_EN: reads of an empty FIFO
//            return SLVERR beats with zero data instead of stalling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi4_burst_fifo
    import axi4_fifo_pkg::*;
#(
    parameter int  DATA_WID  = 64,
    parameter int  ID_WID    = 8,
    parameter int  LEN_WID   = 8,
    parameter int  DEPTH     = 16,
    parameter int  AFULL_THR = DEPTH - 2,
    localparam int LVL_WID   = ptr_wid(DEPTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ID_WID-1:0]     AWID,
    input  logic [LEN_WID-1:0]    AWLEN,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WID-1:0]   WDATA,
    input  logic [DATA_WID/8-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_WID-1:0]     BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ID_WID-1:0]     ARID,
    input  logic [LEN_WID-1:0]    ARLEN,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_WID-1:0]     RID,
    output logic [DATA_WID-1:0]   RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic [LVL_WID-1:0]    level
);

    wr_state_t            wr_state_q, wr_state_d;
    logic [ID_WID-1:0]    awid_q, awid_d;
    logic [LEN_WID-1:0]   awlen_q, awlen_d;
    logic [LEN_WID-1:0]   wbeat_q, wbeat_d;
    logic                 werr_q, werr_d;

    rd_state_t            rd_state_q, rd_state_d;
    logic [ID_WID-1:0]    arid_q, arid_d;
    logic [LEN_WID-1:0]   arlen_q, arlen_d;
    logic [LEN_WID-1:0]   rbeat_q, rbeat_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DATA_WID-1:0]  fifo_rdata;
    logic                 w_last_beat;
    logic                 r_last_beat;
    logic                 unused_wstrb;

    assign unused_wstrb = ^WSTRB;
    assign w_last_beat  = (wbeat_q == awlen_q);
    assign r_last_beat  = (rbeat_q == arlen_q);

    axi4_fifo_core #(
        .DATA_WID  (DATA_WID),
        .DEPTH     (DEPTH),
        .AFULL_THR (AFULL_THR)
    ) u_core (
        .clk_i   (ACLK),
        .rst_ni  (ARESETn),
        .push_i  (fifo_push),
        .wdata_i (WDATA),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (full),
        .empty_o (empty),
        .afull_o (afull),
        .level_o (level)
    );

    always_comb begin
        wr_state_d = wr_state_q;
        awid_d     = awid_q;
        awlen_d    = awlen_q;
        wbeat_d    = wbeat_q;
        werr_d     = werr_q;
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        BVALID     = 1'b0;
        fifo_push  = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) begin
                    awid_d     = AWID;
                    awlen_d    = AWLEN;
                    wbeat_d    = '0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                WREADY = !full;
                if (WVALID && !full) begin
                    fifo_push = 1'b1;
                    // A misplaced WLAST is flagged but the beat is still stored.
                    if (WLAST != w_last_beat) werr_d = 1'b1;
                    if (w_last_beat) wr_state_d = W_RESP;
                    else             wbeat_d    = wbeat_q + 1'b1;
                end
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) begin
                    werr_d     = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign BID   = awid_q;
    assign BRESP = werr_q ? SLVERR : OKAY;
    assign RID   = arid_q;

`ifdef AXI4_FIFO_UNDERFLOW_ERR_EN
    logic uflow_q, uflow_d;
`endif

    always_comb begin
        rd_state_d = rd_state_q;
        arid_d     = arid_q;
        arlen_d    = arlen_q;
        rbeat_d    = rbeat_q;
        ARREADY    = 1'b0;
        RVALID     = 1'b0;
        RLAST      = 1'b0;
        RRESP      = OKAY;
        RDATA      = fifo_rdata;
        fifo_pop   = 1'b0;
`ifdef AXI4_FIFO_UNDERFLOW_ERR_EN
        uflow_d    = 1'b0;
`endif
        case (rd_state_q)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) begin
                    arid_d     = ARID;
                    arlen_d    = ARLEN;
                    rbeat_d    = '0;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                RLAST = r_last_beat;
`ifdef AXI4_FIFO_UNDERFLOW_ERR_EN
                // An error beat, once shown, is held until accepted even if data lands.
                RVALID = 1'b1;
                if (empty || uflow_q) begin
                    RDATA   = '0;
                    RRESP   = SLVERR;
                    uflow_d = !RREADY;
                end else begin
                    fifo_pop = RREADY;
                end
`else
                RVALID   = !empty;
                fifo_pop = !empty && RREADY;
`endif
                if (RVALID && RREADY) begin
                    if (r_last_beat) rd_state_d = R_IDLE;
                    else             rbeat_d    = rbeat_q + 1'b1;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state_q <= W_IDLE;
            awid_q     <= '0;
            awlen_q    <= '0;
            wbeat_q    <= '0;
            werr_q     <= 1'b0;
            rd_state_q <= R_IDLE;
            arid_q     <= '0;
            arlen_q    <= '0;
            rbeat_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            awid_q     <= awid_d;
            awlen_q    <= awlen_d;
            wbeat_q    <= wbeat_d;
            werr_q     <= werr_d;
            rd_state_q <= rd_state_d;
            arid_q     <= arid_d;
            arlen_q    <= arlen_d;
            rbeat_q    <= rbeat_d;
        end
    end

`ifdef AXI4_FIFO_UNDERFLOW_ERR_EN
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) uflow_q <= 1'b0;
        else          uflow_q <= uflow_d;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi4_burst_fifo.sv
// ============================================================================
// Module   : tb_axi4_burst_fifo
// Brief    : Directed self-checking bench for axi4_burst_fifo (DEPTH=16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi4_burst_fifo;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [7:0]  AWID, AWLEN, ARID, ARLEN;
    logic        AWVALID, AWREADY, ARVALID, ARREADY;
    logic [63:0] WDATA, RDATA;
    logic [7:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [7:0]  BID, RID;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY, RLAST, RVALID, RREADY;
    logic        full, empty, afull;
    logic [4:0]  level;

    int vecs = 0;
    int errs = 0;
    int max_level = 0;
    logic mon_en = 1'b0;

    always #5 ACLK = ~ACLK;

    axi4_burst_fifo #(
        .DATA_WID (64), .ID_WID (8), .LEN_WID (8), .DEPTH (16), .AFULL_THR (14)
    ) dut (
        .ACLK (ACLK), .ARESETn (ARESETn),
        .AWID (AWID), .AWLEN (AWLEN), .AWVALID (AWVALID), .AWREADY (AWREADY),
        .WDATA (WDATA), .WSTRB (WSTRB), .WLAST (WLAST), .WVALID (WVALID), .WREADY (WREADY),
        .BID (BID), .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
        .ARID (ARID), .ARLEN (ARLEN), .ARVALID (ARVALID), .ARREADY (ARREADY),
        .RID (RID), .RDATA (RDATA), .RRESP (RRESP), .RLAST (RLAST), .RVALID (RVALID),
        .RREADY (RREADY),
        .full (full), .empty (empty), .afull (afull), .level (level)
    );

    always @(negedge ACLK) begin
        if (mon_en && int'(level) > max_level) max_level = int'(level);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw_send(input logic [7:0] id, input logic [7:0] len);
        int n = 0;
        AWID = id; AWLEN = len; AWVALID = 1'b1;
        while (AWREADY !== 1'b1 && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            vecs++; errs++;
            $display("FAIL aw_timeout: AWREADY=%b required 1", AWREADY);
        end
        tick();
        AWVALID = 1'b0;
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [7:0] len);
        int n = 0;
        ARID = id; ARLEN = len; ARVALID = 1'b1;
        while (ARREADY !== 1'b1 && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            vecs++; errs++;
            $display("FAIL ar_timeout: ARREADY=%b required 1", ARREADY);
        end
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] data, input logic last);
        int n = 0;
        WDATA = data; WLAST = last; WVALID = 1'b1;
        while (WREADY !== 1'b1 && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            vecs++; errs++;
            $display("FAIL w_timeout: WREADY=%b required 1", WREADY);
        end
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic b_get(input int gap, output logic [7:0] id, output logic [1:0] resp);
        int n = 0;
        repeat (gap) tick();
        BREADY = 1'b1;
        while (BVALID !== 1'b1 && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            vecs++; errs++;
            $display("FAIL b_timeout: BVALID=%b required 1", BVALID);
        end
        id = BID; resp = BRESP;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic r_get(input int gap, output logic [63:0] data, output logic [1:0] resp,
                         output logic last, output logic [7:0] id);
        int n = 0;
        repeat (gap) tick();
        RREADY = 1'b1;
        while (RVALID !== 1'b1 && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            vecs++; errs++;
            $display("FAIL r_timeout: RVALID=%b required 1", RVALID);
        end
        data = RDATA; resp = RRESP; last = RLAST; id = RID;
        tick();
        RREADY = 1'b0;
    endtask

    task automatic test_reset;
        ARESETn = 1'b0;
        repeat (2) tick();
        vecs++;
        if ({AWREADY, ARREADY} !== 2'b11) begin
            errs++; $display("FAIL rst_ready: got %b required 11", {AWREADY, ARREADY});
        end
        vecs++;
        if ({WREADY, BVALID, RVALID, RLAST} !== 4'b0000) begin
            errs++; $display("FAIL rst_valid: got %b required 0000", {WREADY, BVALID, RVALID, RLAST});
        end
        vecs++;
        if ({BID, BRESP, RID, RRESP} !== 20'h0) begin
            errs++; $display("FAIL rst_ids: got %h required 0", {BID, BRESP, RID, RRESP});
        end
        vecs++;
        if ({full, empty, afull, level} !== {3'b010, 5'd0}) begin
            errs++; $display("FAIL rst_status: got %b required 01000000", {full, empty, afull, level});
        end
        ARESETn = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        logic [63:0] d; logic [1:0] rs; logic lst; logic [7:0] id;
        aw_send(8'h11, 8'd3);
        for (int i = 0; i < 4; i++) w_beat(64'(160 + i), i == 3);
        b_get(0, id, rs);
        vecs++;
        if (rs !== 2'b00 || id !== 8'h11) begin
            errs++; $display("FAIL basic_b: got id=%h resp=%b required id=11 resp=00", id, rs);
        end
        vecs++;
        if (level !== 5'd4) begin
            errs++; $display("FAIL basic_level: got %0d required 4", level);
        end
        ar_send(8'h22, 8'd3);
        for (int i = 0; i < 4; i++) begin
            r_get(0, d, rs, lst, id);
            vecs++;
            if (d !== 64'(160 + i) || lst !== (i == 3) || id !== 8'h22 || rs !== 2'b00) begin
                errs++;
                $display("FAIL basic_r%0d: got data=%h last=%b id=%h resp=%b required data=%h last=%b id=22 resp=00",
                         i, d, lst, id, rs, 64'(160 + i), (i == 3));
            end
        end
        vecs++;
        if (empty !== 1'b1) begin
            errs++; $display("FAIL basic_empty: got %b required 1", empty);
        end
    endtask

    task automatic test_full;
        logic [63:0] d; logic [1:0] rs; logic lst; logic [7:0] id;
        aw_send(8'h33, 8'd16);
        for (int i = 0; i < 16; i++) begin
            w_beat(64'(256 + i), 1'b0);
            if (i == 12) begin
                vecs++;
                if (afull !== 1'b0 || level !== 5'd13) begin
                    errs++; $display("FAIL afull_13: got afull=%b level=%0d required 0/13", afull, level);
                end
            end
            if (i == 13) begin
                vecs++;
                if (afull !== 1'b1 || level !== 5'd14) begin
                    errs++; $display("FAIL afull_14: got afull=%b level=%0d required 1/14", afull, level);
                end
            end
        end
        vecs++;
        if (full !== 1'b1 || level !== 5'd16) begin
            errs++; $display("FAIL full_16: got full=%b level=%0d required 1/16", full, level);
        end
        WDATA = 64'h110; WLAST = 1'b1; WVALID = 1'b1;
        for (int c = 0; c < 3; c++) begin
            vecs++;
            if (WREADY !== 1'b0 || level !== 5'd16) begin
                errs++; $display("FAIL full_stall%0d: got wready=%b level=%0d required 0/16", c, WREADY, level);
            end
            tick();
        end
        ar_send(8'h44, 8'd0);
        RREADY = 1'b1;
        vecs++;
        if (RVALID !== 1'b1 || RDATA !== 64'h100 || RLAST !== 1'b1 || WREADY !== 1'b0) begin
            errs++;
            $display("FAIL full_pop: got rvalid=%b data=%h last=%b wready=%b required 1/100/1/0",
                     RVALID, RDATA, RLAST, WREADY);
        end
        tick();
        RREADY = 1'b0;
        vecs++;
        if (WREADY !== 1'b1 || full !== 1'b0 || level !== 5'd15) begin
            errs++; $display("FAIL full_free: got wready=%b full=%b level=%0d required 1/0/15", WREADY, full, level);
        end
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
        vecs++;
        if (level !== 5'd16) begin
            errs++; $display("FAIL full_17th: got level=%0d required 16", level);
        end
        b_get(0, id, rs);
        vecs++;
        if (rs !== 2'b00 || id !== 8'h33) begin
            errs++; $display("FAIL full_b: got id=%h resp=%b required 33/00", id, rs);
        end
        ar_send(8'h45, 8'd15);
        for (int i = 0; i < 16; i++) begin
            r_get(0, d, rs, lst, id);
            vecs++;
            if (d !== 64'(257 + i) || lst !== (i == 15)) begin
                errs++; $display("FAIL full_drain%0d: got %h last=%b required %h last=%b",
                                 i, d, lst, 64'(257 + i), (i == 15));
            end
        end
        vecs++;
        if (empty !== 1'b1) begin
            errs++; $display("FAIL full_empty: got %b required 1", empty);
        end
    endtask

    task automatic test_wlast_err;
        logic [63:0] d; logic [1:0] rs; logic lst; logic [7:0] id;
        aw_send(8'h5A, 8'd3);
        for (int i = 0; i < 4; i++) w_beat(64'(48 + i), i == 2);
        b_get(0, id, rs);
        vecs++;
        if (rs !== 2'b10 || id !== 8'h5A || level !== 5'd4) begin
            errs++; $display("FAIL wlast_err: got resp=%b id=%h level=%0d required 10/5a/4", rs, id, level);
        end
        ar_send(8'h5B, 8'd3);
        for (int i = 0; i < 4; i++) begin
            r_get(0, d, rs, lst, id);
            vecs++;
            if (d !== 64'(48 + i)) begin
                errs++; $display("FAIL wlast_data%0d: got %h required %h", i, d, 64'(48 + i));
            end
        end
        aw_send(8'h5C, 8'd0);
        w_beat(64'h77, 1'b1);
        b_get(0, id, rs);
        vecs++;
        if (rs !== 2'b00 || id !== 8'h5C) begin
            errs++; $display("FAIL wlast_clear: got resp=%b id=%h required 00/5c", rs, id);
        end
        ar_send(8'h5D, 8'd0);
        r_get(0, d, rs, lst, id);
    endtask

    task automatic test_stream;
        max_level = 0;
        mon_en = 1'b1;
        fork
            begin
                logic [1:0] wrs; logic [7:0] wid;
                for (int b = 0; b < 10; b++) begin
                    aw_send(8'(b), 8'd3);
                    for (int k = 0; k < 4; k++) w_beat(64'(4096 + b * 4 + k), k == 3);
                    b_get(int'($urandom_range(0, 3)), wid, wrs);
                    vecs++;
                    if (wrs !== 2'b00 || wid !== 8'(b)) begin
                        errs++; $display("FAIL stream_b%0d: got resp=%b id=%h required 00/%h", b, wrs, wid, 8'(b));
                    end
                end
            end
            begin
                logic [63:0] rd; logic [1:0] rrs; logic rl; logic [7:0] rid;
                for (int b = 0; b < 10; b++) begin
                    ar_send(8'(128 + b), 8'd3);
                    for (int k = 0; k < 4; k++) begin
                        r_get(int'($urandom_range(0, 2)), rd, rrs, rl, rid);
                        vecs++;
                        if (rd !== 64'(4096 + b * 4 + k) || rl !== (k == 3)) begin
                            errs++; $display("FAIL stream_r%0d: got %h last=%b required %h last=%b",
                                             b * 4 + k, rd, rl, 64'(4096 + b * 4 + k), (k == 3));
                        end
                    end
                end
            end
        join
        mon_en = 1'b0;
        vecs++;
        if (max_level > 16 || empty !== 1'b1) begin
            errs++; $display("FAIL stream_level: got max=%0d empty=%b required <=16/1", max_level, empty);
        end
    endtask

    task automatic test_underflow;
        logic [63:0] d; logic [1:0] rs; logic lst; logic [7:0] id;
        ar_send(8'h66, 8'd1);
`ifdef AXI4_FIFO_UNDERFLOW_ERR_EN
        for (int i = 0; i < 2; i++) begin
            r_get(0, d, rs, lst, id);
            vecs++;
            if (d !== 64'h0 || rs !== 2'b10 || lst !== (i == 1) || id !== 8'h66) begin
                errs++; $display("FAIL uflow_r%0d: got data=%h resp=%b last=%b id=%h required 0/10/%b/66",
                                 i, d, rs, lst, id, (i == 1));
            end
        end
        vecs++;
        if (empty !== 1'b1 || ARREADY !== 1'b1) begin
            errs++; $display("FAIL uflow_idle: got empty=%b arready=%b required 1/1", empty, ARREADY);
        end
`else
        begin
            int seen = 0;
            for (int c = 0; c < 5; c++) begin
                if (RVALID !== 1'b0) seen++;
                tick();
            end
            vecs++;
            if (seen != 0) begin
                errs++; $display("FAIL uflow_stall: rvalid high on %0d cycles required 0", seen);
            end
        end
        aw_send(8'h67, 8'd0);
        w_beat(64'hBEEF, 1'b1);
        vecs++;
        if (RVALID !== 1'b1) begin
            errs++; $display("FAIL uflow_visible: got rvalid=%b required 1", RVALID);
        end
        r_get(0, d, rs, lst, id);
        vecs++;
        if (d !== 64'hBEEF || lst !== 1'b0 || rs !== 2'b00 || id !== 8'h66) begin
            errs++; $display("FAIL uflow_r0: got %h last=%b resp=%b id=%h required beef/0/00/66", d, lst, rs, id);
        end
        b_get(0, id, rs);
        aw_send(8'h68, 8'd0);
        w_beat(64'hCAFE, 1'b1);
        b_get(0, id, rs);
        r_get(0, d, rs, lst, id);
        vecs++;
        if (d !== 64'hCAFE || lst !== 1'b1) begin
            errs++; $display("FAIL uflow_r1: got %h last=%b required cafe/1", d, lst);
        end
`endif
    endtask

    task automatic test_reset_mid;
        logic [63:0] d; logic [1:0] rs; logic lst; logic [7:0] id;
        aw_send(8'h77, 8'd3);
        w_beat(64'hD0, 1'b0);
        w_beat(64'hD1, 1'b0);
        vecs++;
        if (level !== 5'd2 || WREADY !== 1'b1) begin
            errs++; $display("FAIL mid_pre: got level=%0d wready=%b required 2/1", level, WREADY);
        end
        #2 ARESETn = 1'b0;
        #1;
        vecs++;
        if ({AWREADY, WREADY, BVALID, empty, full, level} !== {5'b10010, 5'd0}) begin
            errs++; $display("FAIL mid_async: got %b required 1001000000",
                             {AWREADY, WREADY, BVALID, empty, full, level});
        end
        #2 ARESETn = 1'b1;
        tick();
        aw_send(8'h78, 8'd1);
        w_beat(64'hE0, 1'b0);
        w_beat(64'hE1, 1'b1);
        b_get(0, id, rs);
        vecs++;
        if (rs !== 2'b00 || id !== 8'h78) begin
            errs++; $display("FAIL mid_b: got resp=%b id=%h required 00/78", rs, id);
        end
        ar_send(8'h79, 8'd1);
        for (int i = 0; i < 2; i++) begin
            r_get(0, d, rs, lst, id);
            vecs++;
            if (d !== 64'(224 + i) || lst !== (i == 1)) begin
                errs++; $display("FAIL mid_r%0d: got %h last=%b required %h last=%b",
                                 i, d, lst, 64'(224 + i), (i == 1));
            end
        end
    endtask

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWLEN = '0; AWVALID = 1'b0;
        ARID = '0; ARLEN = '0; ARVALID = 1'b0;
        WDATA = '0; WSTRB = '1; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0; RREADY = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_wlast_err();
        test_stream();
        test_underflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
